// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the crypto ISE co-processor control path:
// result codes, sequencer states and instruction-class widths.
package scarv_cop_pkg;

    localparam int unsigned COP_CLASS_W = 3;
    localparam int unsigned COP_NCLASS  = 8;
    localparam int unsigned COP_RES_W   = 3;

    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_SUCCESS = 3'd0;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_ABORT   = 3'd1;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_BAD_INS = 3'd2;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_BAD_LAD = 3'd3;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_BAD_SAD = 3'd4;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_MEM_ERR = 3'd5;
    localparam logic [COP_RES_W-1:0] SCARV_COP_INSN_TIMEOUT = 3'd6;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_DECODE,
        CTRL_EXEC,
        CTRL_RESP
    } ctrl_state_t;

    function automatic logic [COP_NCLASS-1:0] class_onehot(input logic [COP_CLASS_W-1:0] cls);
        logic [COP_NCLASS-1:0] one;
        one = COP_NCLASS'(1);
        return one << cls;
    endfunction

endpackage

// File: rtl/scarv_cop_ctrl_wdog.sv
// Execution watchdog: counts EXEC cycles and flags the last permitted one.
module scarv_cop_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/scarv_cop_ctrl.sv
// Co-processor instruction sequencer: CPU request/response/abort handshakes,
// decode dispatch, execution start and GPR writeback.
module scarv_cop_ctrl
    import scarv_cop_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,

    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic        cpu_abort_req,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,

    output logic [31:0] insn_enc_q,
    output logic [31:0] insn_rs1_q,

    input  logic        id_exception,
    input  logic [2:0]  id_class,
    input  logic [4:0]  id_rd,

    output logic [7:0]  ex_start,
    output logic        ex_flush,
    input  logic        ex_done,
    input  logic [2:0]  ex_result,
    input  logic        ex_gpr_wen,
    input  logic [31:0] ex_gpr_wdata,

    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic [2:0]  cop_result,
    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic [4:0]  rd_q;
    logic        load_insn;
    logic        load_rd;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_expired;
    logic        abort_kill;
    logic        resp_load;
    logic        resp_clear;
    logic        resp_wen;
    logic [4:0]  resp_waddr;
    logic [31:0] resp_wdata;
    logic [2:0]  resp_result;

    scarv_cop_ctrl_wdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .clr      (wd_clr),
        .en       (wd_en),
        .expired  (wd_expired)
    );

    assign cop_insn_ack = (state == CTRL_IDLE);
    assign g_clk_req    = cpu_insn_req || (state != CTRL_IDLE);
    assign ex_flush     = !g_resetn || abort_kill;

    always_comb begin
        next_state  = state;
        load_insn   = 1'b0;
        load_rd     = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        abort_kill  = 1'b0;
        resp_load   = 1'b0;
        resp_clear  = 1'b0;
        resp_wen    = 1'b0;
        resp_waddr  = '0;
        resp_wdata  = '0;
        resp_result = SCARV_COP_INSN_SUCCESS;
        ex_start    = '0;
        case (state)
            CTRL_IDLE: begin
                if (cpu_insn_req) begin
                    load_insn  = 1'b1;
                    next_state = CTRL_DECODE;
                end
            end
            CTRL_DECODE: begin
                if (cpu_abort_req) begin
                    resp_load   = 1'b1;
                    resp_result = SCARV_COP_INSN_ABORT;
                    next_state  = CTRL_RESP;
                end else if (id_exception) begin
                    resp_load   = 1'b1;
                    resp_result = SCARV_COP_INSN_BAD_INS;
                    next_state  = CTRL_RESP;
                end else begin
                    ex_start   = class_onehot(id_class);
                    wd_clr     = 1'b1;
                    load_rd    = 1'b1;
                    next_state = CTRL_EXEC;
                end
            end
            CTRL_EXEC: begin
                wd_en = 1'b1;
                // Completion outranks abort and timeout so finished work is never discarded.
                if (ex_done) begin
                    resp_load   = 1'b1;
                    resp_result = ex_result;
                    resp_wen    = ex_gpr_wen && (ex_result == SCARV_COP_INSN_SUCCESS);
                    resp_waddr  = rd_q;
                    resp_wdata  = ex_gpr_wdata;
                    next_state  = CTRL_RESP;
                end else if (cpu_abort_req) begin
                    abort_kill  = 1'b1;
                    resp_load   = 1'b1;
                    resp_result = SCARV_COP_INSN_ABORT;
                    next_state  = CTRL_RESP;
                end else if (wd_expired) begin
                    abort_kill  = 1'b1;
                    resp_load   = 1'b1;
                    resp_result = SCARV_COP_INSN_TIMEOUT;
                    next_state  = CTRL_RESP;
                end
            end
            CTRL_RESP: begin
                if (cpu_insn_ack) begin
                    resp_clear = 1'b1;
                    next_state = CTRL_IDLE;
                end
            end
            default: next_state = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state        <= CTRL_IDLE;
            insn_enc_q   <= '0;
            insn_rs1_q   <= '0;
            rd_q         <= '0;
            cop_wen      <= 1'b0;
            cop_waddr    <= '0;
            cop_wdata    <= '0;
            cop_result   <= '0;
            cop_insn_rsp <= 1'b0;
        end else begin
            state <= next_state;
            if (load_insn) begin
                insn_enc_q <= cpu_insn_enc;
                insn_rs1_q <= cpu_rs1;
            end
            if (load_rd) begin
                rd_q <= id_rd;
            end
            if (resp_load) begin
                cop_wen      <= resp_wen;
                cop_waddr    <= resp_waddr;
                cop_wdata    <= resp_wdata;
                cop_result   <= resp_result;
                cop_insn_rsp <= 1'b1;
            end else if (resp_clear) begin
                cop_wen      <= 1'b0;
                cop_waddr    <= '0;
                cop_wdata    <= '0;
                cop_result   <= '0;
                cop_insn_rsp <= 1'b0;
            end
        end
    end

endmodule
